// File: rtl/timer_periodic_if.sv
// Control and status bundle for the programmable periodic timer.
// The master side drives commands; the timer implements the slave side.
interface timer_periodic_if #(
   parameter int WIDTH = 24,
   parameter int EXP_W = 8
);
   logic             start;
   logic             stop;
   logic             one_shot;
   logic             load;
   logic [WIDTH-1:0] load_period;
   logic [WIDTH-1:0] count;
   logic [WIDTH-1:0] period;
   logic             output_pulse;
   logic             running;
   logic [EXP_W-1:0] expiries;

   modport master (
      output start, stop, one_shot, load, load_period,
      input  count, period, output_pulse, running, expiries
   );

   modport slave (
      input  start, stop, one_shot, load, load_period,
      output count, period, output_pulse, running, expiries
   );
endinterface

// File: rtl/timer_periodic.sv
// Programmable periodic/one-shot tick generator with a shadowed period
// register and a wrapping expiry counter; all outputs are registered.
module timer_periodic #(
   parameter int WIDTH          = 24,
   parameter int DEFAULT_PERIOD = 12_000_000,
   parameter int EXP_W          = 8
) (
   input logic              clk,
   input logic              rst,
   timer_periodic_if.slave  bus
);

   typedef enum logic {IDLE, RUN} state_t;

   // A zero default period would never expire, so it is promoted to one cycle.
   localparam logic [WIDTH-1:0] RESET_PERIOD =
      (DEFAULT_PERIOD == 0) ? WIDTH'(1) : WIDTH'(DEFAULT_PERIOD);

   state_t           state_q, state_d;
   logic             one_shot_q, one_shot_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] active_q, active_d;
   logic [WIDTH-1:0] shadow_q, shadow_d;
   logic             pulse_q, pulse_d;
   logic [EXP_W-1:0] exp_q, exp_d;

   logic [WIDTH-1:0] eff_period;
   logic             last_tick;

   assign eff_period = (active_q == '0) ? WIDTH'(1) : active_q;
   assign last_tick  = (count_q >= (eff_period - WIDTH'(1)));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         one_shot_q <= 1'b0;
         count_q    <= '0;
         active_q   <= RESET_PERIOD;
         shadow_q   <= RESET_PERIOD;
         pulse_q    <= 1'b0;
         exp_q      <= '0;
      end else begin
         state_q    <= state_d;
         one_shot_q <= one_shot_d;
         count_q    <= count_d;
         active_q   <= active_d;
         shadow_q   <= shadow_d;
         pulse_q    <= pulse_d;
         exp_q      <= exp_d;
      end
   end

   // Priority is stop, then start, then normal counting; a load landing on a
   // wrap edge overrides the stale shadow so the newest value wins.
   always_comb begin
      state_d    = state_q;
      one_shot_d = one_shot_q;
      count_d    = count_q;
      active_d   = active_q;
      shadow_d   = bus.load ? bus.load_period : shadow_q;
      pulse_d    = 1'b0;
      exp_d      = exp_q;

      if (bus.load && ((state_q == IDLE) || bus.start)) begin
         active_d = bus.load_period;
      end

      if (bus.stop) begin
         state_d = IDLE;
      end else if (bus.start) begin
         state_d    = RUN;
         count_d    = '0;
         one_shot_d = bus.one_shot;
      end else if (state_q == RUN) begin
         if (last_tick) begin
            count_d  = '0;
            pulse_d  = 1'b1;
            exp_d    = exp_q + EXP_W'(1);
            active_d = bus.load ? bus.load_period : shadow_q;
            if (one_shot_q) begin
               state_d = IDLE;
            end
         end else begin
            count_d = count_q + WIDTH'(1);
         end
      end
   end

   assign bus.count        = count_q;
   assign bus.period       = active_q;
   assign bus.output_pulse = pulse_q;
   assign bus.running      = (state_q == RUN);
   assign bus.expiries     = exp_q;

endmodule
